// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the multicycle MIPS datapath/control.
//   state_t     : 4-bit control FSM state encoding
//   OP_*        : opcode field values (instr[31:26])
//   FUNCT_*     : R-type funct field values (instr[5:0])
//   ALU_*       : alucon operation codes, shared with the ALU itself
//   SRCB_*      : alusrcb select values
//   PCSRC_*     : pcsrc select values
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder -- purely combinational R-type funct decode.
//   i_funct   [5:0] : instruction funct field
//   o_alucon  [2:0] : ALU operation (ADD for unsupported funct)
//   o_illegal       : high when funct is not a supported R-type operation
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucon,
  output logic       o_illegal
);

  always_comb begin
    o_alucon  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_funct)
      FUNCT_ADD: o_alucon = ALU_ADD;
      FUNCT_SUB: o_alucon = ALU_SUB;
      FUNCT_AND: o_alucon = ALU_AND;
      FUNCT_OR:  o_alucon = ALU_OR;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl -- Moore control FSM for a multicycle MIPS subset
// (lw, sw, R-type add/sub/and/or, beq, addi, j).
//   clk, rst (async, active high)
//   opcode[5:0], funct[5:0] : instruction fields, sampled only in DECODE/RTYPEEX
//   zero                    : ALU result == 0, used for beq
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen
//   alusrcb[1:0], pcsrc[1:0], alucon[2:0] : datapath controls
//   illegal                 : one-cycle pulse on unsupported opcode/funct
//   instr_done              : one-cycle pulse in the final state of a retired instr
//   dbg_state               : current FSM state
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic       pcen,
  output logic       illegal,
  output logic       instr_done,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucon,
  output state_t     dbg_state
);

  state_t r_state;
  state_t w_next;

  // lw/sw distinction captured in DECODE so MEMADR does not look at opcode.
  logic r_is_sw;

  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_illegal, w_done, w_pcwrite, w_branch;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_alucon;
  logic [2:0] w_dec_alucon;
  logic       w_dec_illegal;

  alu_decoder u_alu_decoder (
    .i_funct   (funct),
    .o_alucon  (w_dec_alucon),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_is_sw <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_is_sw <= (opcode == OP_SW);
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_illegal  = 1'b0;
    w_done     = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_alusrcb  = SRCB_REG;
    w_pcsrc    = PCSRC_ALU;
    w_alucon   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_alusrcb = SRCB_FOUR;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        w_alusrcb = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
        if (r_state == S_ADDIEX) w_next = S_ADDIWB;
        else                     w_next = r_is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_alucon  = w_dec_alucon;
        if (w_dec_illegal) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_RTYPEWB;
        end
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_alucon  = ALU_SUB;
        w_pcsrc   = PCSRC_ALUOUT;
        w_branch  = 1'b1;
        w_done    = 1'b1;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_JEX: begin
        w_pcsrc   = PCSRC_JUMP;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks every output combinationally: the state register already
  // holds FETCH during reset, and FETCH would otherwise assert irwrite/pcen.
  assign iord       = ~rst & w_iord;
  assign memwrite   = ~rst & w_memwrite;
  assign irwrite    = ~rst & w_irwrite;
  assign regdst     = ~rst & w_regdst;
  assign memtoreg   = ~rst & w_memtoreg;
  assign regwrite   = ~rst & w_regwrite;
  assign alusrca    = ~rst & w_alusrca;
  assign illegal    = ~rst & w_illegal;
  assign instr_done = ~rst & w_done;
  assign pcen       = ~rst & (w_pcwrite | (w_branch & zero));
  assign alusrcb    = rst ? 2'b00 : w_alusrcb;
  assign pcsrc      = rst ? 2'b00 : w_pcsrc;
  assign alucon     = rst ? 3'b000 : w_alucon;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl -- directed, self-checking bench for the control FSM.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode = 6'd0;
  logic [5:0] funct  = 6'd0;
  logic       zero   = 1'b0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic       pcen, illegal, instr_done;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucon;
  state_t     dbg_state;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .pcen       (pcen),
    .illegal    (illegal),
    .instr_done (instr_done),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucon     (alucon),
    .dbg_state  (dbg_state)
  );

  // Output vector layout: flags[9:0] | alusrcb | pcsrc | alucon
  localparam logic [9:0] F_IORD     = 10'h200;
  localparam logic [9:0] F_MEMWRITE = 10'h100;
  localparam logic [9:0] F_IRWRITE  = 10'h080;
  localparam logic [9:0] F_REGDST   = 10'h040;
  localparam logic [9:0] F_MEMTOREG = 10'h020;
  localparam logic [9:0] F_REGWRITE = 10'h010;
  localparam logic [9:0] F_ALUSRCA  = 10'h008;
  localparam logic [9:0] F_PCEN     = 10'h004;
  localparam logic [9:0] F_ILLEGAL  = 10'h002;
  localparam logic [9:0] F_DONE     = 10'h001;

  logic [16:0] outs;
  assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 pcen, illegal, instr_done, alusrcb, pcsrc, alucon};

  function automatic logic [16:0] ov(input logic [9:0] f, input logic [1:0] srcb,
                                     input logic [1:0] pcs, input logic [2:0] alu);
    return {f, srcb, pcs, alu};
  endfunction

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One FSM cycle: inputs already driven at the negedge; sample 1ns later.
  task automatic cyc(input string tag, input state_t es, input logic [16:0] ev);
    #1;
    check({tag, "_state"}, 32'(dbg_state), 32'(es));
    check({tag, "_outs"}, 32'(outs), 32'(ev));
    @(negedge clk);
  endtask

  logic [5:0] rt_f[4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
  logic [2:0] rt_a[4] = '{3'b000, 3'b001, 3'b010, 3'b011};

  logic [16:0] e_fetch, e_dec, e_dec_ill, e_adr, e_memrd, e_memwb, e_memwr;
  logic [16:0] e_rtex_ill, e_rtwb, e_addiwb, e_jex, e_beq_t, e_beq_n;

  initial begin
    e_fetch    = ov(F_IRWRITE | F_PCEN, 2'b01, 2'b00, 3'b000);
    e_dec      = ov(10'h0, 2'b11, 2'b00, 3'b000);
    e_dec_ill  = ov(F_ILLEGAL, 2'b11, 2'b00, 3'b000);
    e_adr      = ov(F_ALUSRCA, 2'b10, 2'b00, 3'b000);
    e_memrd    = ov(F_IORD, 2'b00, 2'b00, 3'b000);
    e_memwb    = ov(F_MEMTOREG | F_REGWRITE | F_DONE, 2'b00, 2'b00, 3'b000);
    e_memwr    = ov(F_IORD | F_MEMWRITE | F_DONE, 2'b00, 2'b00, 3'b000);
    e_rtex_ill = ov(F_ALUSRCA | F_ILLEGAL, 2'b00, 2'b00, 3'b000);
    e_rtwb     = ov(F_REGDST | F_REGWRITE | F_DONE, 2'b00, 2'b00, 3'b000);
    e_addiwb   = ov(F_REGWRITE | F_DONE, 2'b00, 2'b00, 3'b000);
    e_jex      = ov(F_PCEN | F_DONE, 2'b00, 2'b10, 3'b000);
    e_beq_t    = ov(F_ALUSRCA | F_PCEN | F_DONE, 2'b00, 2'b01, 3'b001);
    e_beq_n    = ov(F_ALUSRCA | F_DONE, 2'b00, 2'b01, 3'b001);

    // reset state: everything low while rst is high
    @(negedge clk); @(negedge clk);
    #1;
    check("reset_state", 32'(dbg_state), 32'(S_FETCH));
    check("reset_outs", 32'(outs), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // lw: 5 cycles; opcode changes after DECODE must not matter
    opcode = 6'b100011; zero = 1'b1;
    cyc("lw_fetch", S_FETCH, e_fetch);
    cyc("lw_dec", S_DECODE, e_dec);
    opcode = 6'b101011;
    cyc("lw_adr", S_MEMADR, e_adr);
    cyc("lw_rd", S_MEMRD, e_memrd);
    cyc("lw_wb", S_MEMWB, e_memwb);

    // sw: 4 cycles
    opcode = 6'b101011; zero = 1'b0;
    cyc("sw_fetch", S_FETCH, e_fetch);
    cyc("sw_dec", S_DECODE, e_dec);
    opcode = 6'b100011;
    cyc("sw_adr", S_MEMADR, e_adr);
    cyc("sw_wr", S_MEMWR, e_memwr);

    // R-type, each supported funct; funct scrambled in RTYPEWB
    for (int i = 0; i < 4; i++) begin
      opcode = 6'b000000; funct = rt_f[i];
      cyc("rt_fetch", S_FETCH, e_fetch);
      cyc("rt_dec", S_DECODE, e_dec);
      cyc($sformatf("rt_ex%0d", i), S_RTYPEEX, ov(F_ALUSRCA, 2'b00, 2'b00, rt_a[i]));
      funct = 6'b101010;
      cyc("rt_wb", S_RTYPEWB, e_rtwb);
    end

    // addi: 4 cycles
    opcode = 6'b001000;
    cyc("addi_fetch", S_FETCH, e_fetch);
    cyc("addi_dec", S_DECODE, e_dec);
    cyc("addi_ex", S_ADDIEX, e_adr);
    cyc("addi_wb", S_ADDIWB, e_addiwb);

    // beq taken / not taken: 3 cycles each
    opcode = 6'b000100; zero = 1'b0;
    cyc("beqt_fetch", S_FETCH, e_fetch);
    cyc("beqt_dec", S_DECODE, e_dec);
    zero = 1'b1;
    cyc("beqt_ex", S_BEQEX, e_beq_t);
    zero = 1'b1;
    cyc("beqn_fetch", S_FETCH, e_fetch);
    cyc("beqn_dec", S_DECODE, e_dec);
    zero = 1'b0;
    cyc("beqn_ex", S_BEQEX, e_beq_n);

    // j: 3 cycles
    opcode = 6'b000010;
    cyc("j_fetch", S_FETCH, e_fetch);
    cyc("j_dec", S_DECODE, e_dec);
    cyc("j_ex", S_JEX, e_jex);

    // illegal opcode: 2 cycles, no instr_done
    opcode = 6'b111111;
    cyc("illop_fetch", S_FETCH, e_fetch);
    cyc("illop_dec", S_DECODE, e_dec_ill);

    // illegal funct: back to FETCH, no register write
    opcode = 6'b000000; funct = 6'b101010;
    cyc("illfn_fetch", S_FETCH, e_fetch);
    cyc("illfn_dec", S_DECODE, e_dec);
    cyc("illfn_ex", S_RTYPEEX, e_rtex_ill);

    // async reset in the middle of MEMWR
    opcode = 6'b101011;
    cyc("rsw_fetch", S_FETCH, e_fetch);
    cyc("rsw_dec", S_DECODE, e_dec);
    cyc("rsw_adr", S_MEMADR, e_adr);
    #1;
    check("rsw_memwrite_pre", 32'(memwrite), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rsw_memwrite_async", 32'(memwrite), 32'h0);
    check("rsw_state_async", 32'(dbg_state), 32'(S_FETCH));
    check("rsw_outs_async", 32'(outs), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    opcode = 6'b000010;
    cyc("post_fetch", S_FETCH, e_fetch);
    cyc("post_dec", S_DECODE, e_dec);
    cyc("post_jex", S_JEX, e_jex);
    cyc("post_fetch2", S_FETCH, e_fetch);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL expose clk, input, 1, single system clock; all state updates occur on rising edge.
REQ-002 SHALL expose rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL expose opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-004 SHALL expose funct, input, 6, instruction bits [5:0] from the instruction register.
REQ-005 SHALL expose zero, input, 1, high when the ALU result equals 0.
REQ-006 SHALL expose the following 1-bit outputs: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal, instr_done.
REQ-007 SHALL expose alusrcb, output, 2, ALU B-operand select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
REQ-008 SHALL expose pcsrc, output, 2, next-PC select: 00 = ALU result, 01 = ALU output register, 10 = jump target.
REQ-009 SHALL expose alucon, output, 3, ALU operation code: 000 = add, 001 = sub, 010 = and, 011 = or; codes 1xx are never driven.

Function
REQ-010 SHALL implement a Moore FSM with the following states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-011 SHALL transition FETCH->DECODE unconditionally.
REQ-012 SHALL transition from DECODE by opcode: lw 100011 or sw 101011 -> MEMADR; R-type 000000 -> RTYPEEX; beq 000100 -> BEQEX; addi 001000 -> ADDIEX; j 000010 -> JEX; any other opcode -> FETCH.
REQ-013 SHALL transition MEMADR->MEMRD for lw and MEMADR->MEMWR for sw.
REQ-014 SHALL follow MEMRD->MEMWB, RTYPEEX->RTYPEWB and ADDIEX->ADDIWB.
REQ-015 SHALL return to FETCH from MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX.
REQ-016 SHALL in FETCH drive iord=0, irwrite=1, alusrca=0, alusrcb=01, alucon=000, pcsrc=00, pcwrite=1.
REQ-017 SHALL in DECODE drive alusrca=0, alusrcb=11, alucon=000 to precompute the branch target.
REQ-018 SHALL in MEMADR and ADDIEX drive alusrca=1, alusrcb=10, alucon=000.
REQ-019 SHALL in MEMRD drive iord=1; in MEMWR drive iord=1 and memwrite=1.
REQ-020 SHALL in MEMWB drive regdst=0, memtoreg=1, regwrite=1; in ADDIWB drive regdst=0, memtoreg=0, regwrite=1; in RTYPEWB drive regdst=1, memtoreg=0, regwrite=1.
REQ-021 SHALL in RTYPEEX drive alusrca=1, alusrcb=00 and alucon by funct: 100000->000, 100010->001, 100100->010, 100101->011.
REQ-022 SHALL, for an unsupported funct in RTYPEEX, drive alucon=000, go to FETCH instead of RTYPEWB (no register write), and pulse illegal.
REQ-023 SHALL in BEQEX drive alusrca=1, alusrcb=00, alucon=001, pcsrc=01, branch=1.
REQ-024 SHALL in JEX drive pcsrc=10, pcwrite=1.
REQ-025 SHALL compute pcen combinationally as pcwrite OR (branch AND zero), where pcwrite and branch are internal state decodes.
REQ-026 SHALL drive every output not listed for a state to 0 in that state.
REQ-027 SHALL pulse illegal high for exactly one cycle in DECODE when the opcode is unsupported.
REQ-028 SHALL pulse instr_done for one cycle in the final state of each retired instruction (MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX); instr_done SHALL NOT assert on illegal paths.
REQ-029 SHALL have the following per-instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-030 SHALL sample opcode and funct only in DECODE and RTYPEEX; changes to these inputs in any other state SHALL have no effect.

Reset
REQ-031 SHALL force state to FETCH immediately on rst assertion, including in the middle of an instruction.
REQ-032 SHALL force all outputs to 0 while rst is high, including irwrite, pcen and alusrcb, with no memory or register side effects.
REQ-033 SHALL begin FETCH behaviour on the first rising clk edge after rst deasserts.

Structure
REQ-034 SHALL define the state encoding (4-bit), the opcode and funct constants, and the alucon constants ADD=000, SUB=001, AND=010, OR=011 in a shared package mips_pkg, which the ALU will also use.
REQ-035 SHALL be implemented as a single sequential FSM with one natural sub-module, alu_decoder (funct -> alucon, illegal), which is purely combinational.

Verification
REQ-036 SHALL verify: lw opcode=100011 after reset -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; instr_done in cycle 5.
REQ-037 SHALL verify: R-type with funct=100010 -> alucon=001 in RTYPEEX; regdst=1 and regwrite=1 in the next cycle; total 4 cycles.
REQ-038 SHALL verify: beq with zero=1 in BEQEX -> pcen=1 and pcsrc=01; with zero=0 -> pcen=0; both cases return to FETCH after 3 cycles.
REQ-039 SHALL verify: opcode=111111 -> illegal pulses in DECODE, next state is FETCH, and instr_done is never asserted.
REQ-040 SHALL verify: R-type with funct=101010 -> illegal pulses, regwrite stays 0, and the next state is FETCH.
REQ-041 SHALL verify: rst asserted asynchronously mid-cycle during MEMWR -> memwrite falls to 0 without waiting for a clk edge; after release the FSM executes FETCH.
